// File: rtl/shift_add_pkg.sv
// Shared types and constants for the 4x4 shift-and-add multiplier.
// Holds the FSM state encoding and the product-assembly helper.
package shift_add_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;
  localparam int N_ITER = 4;

  localparam logic [1:0] LAST_ITER = 2'(N_ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Adder carry and sum become the new upper half; the multiplier shifts right underneath.
  function automatic logic [PROD_W-1:0] shift_in(input logic            cout,
                                                 input logic [OP_W-1:0] sum,
                                                 input logic [OP_W-1:0] q);
    return {cout, sum, q[OP_W-1:1]};
  endfunction

endpackage

// File: rtl/parallel_adder_4bit.sv
// 4-bit ripple-carry parallel adder: s/c_out = a + b + c_in.
// Shared adder stage consumed by the shift-and-add multiplier.
module parallel_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  logic [4:0] carry_s;

  // Ripple the carry through four full-adder cells.
  always_comb begin
    carry_s    = 5'b0_0000;
    carry_s[0] = c_in;
    s          = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      s[i]         = a[i] ^ b[i] ^ carry_s[i];
      carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end
    c_out = carry_s[4];
  end

endmodule

// File: rtl/shift_add_mult_4bit.sv
// Sequential 4x4 unsigned shift-and-add multiplier with valid/ready handshakes.
// One partial product per cycle through a single parallel_adder_4bit; 4 iterations.
module shift_add_mult_4bit
  import shift_add_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      a,
  input  logic [OP_W-1:0]      b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PROD_W-1:0]    p,
  output logic                 busy
);

  state_e              state_q, state_d;
  logic [OP_W-1:0]     m_q, m_d;
  logic [OP_W-1:0]     acc_q, acc_d;
  logic [OP_W-1:0]     q_q, q_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [PROD_W-1:0]   p_q, p_d;

  logic [OP_W-1:0]     add_b_s;
  logic [OP_W-1:0]     sum_s;
  logic                cout_s;
  logic [PROD_W-1:0]   step_s;

  assign add_b_s = q_q[0] ? m_q : 4'b0000;

  parallel_adder_4bit u_adder (
    .a     (acc_q),
    .b     (add_b_s),
    .c_in  (1'b0),
    .s     (sum_s),
    .c_out (cout_s)
  );

  assign step_s = shift_in(cout_s, sum_s, q_q);

  // Next-state and datapath update; DONE with both handshakes reloads straight into CALC.
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    acc_d    = acc_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          m_d     = a;
          q_d     = b;
          acc_d   = 4'b0000;
          cnt_d   = 2'd0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        {acc_d, q_d} = step_s;
        cnt_d        = cnt_q + 2'd1;
        if (cnt_q == LAST_ITER) begin
          p_d     = step_s;
          state_d = DONE;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready && in_valid) begin
          m_d     = a;
          q_d     = b;
          acc_d   = 4'b0000;
          cnt_d   = 2'd0;
          state_d = CALC;
        end else if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= 4'b0000;
      acc_q   <= 4'b0000;
      q_q     <= 4'b0000;
      cnt_q   <= 2'd0;
      p_q     <= 8'h00;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC);
  assign p         = p_q;

endmodule

// File: tb/tb_shift_add_mult_4bit.sv
// Self-checking bench for shift_add_mult_4bit: directed scenarios plus a
// randomized exhaustive sweep checked against plain a*b in a FIFO model.
module tb_shift_add_mult_4bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] p;
  logic       busy;

  int tests = 0;
  int fails = 0;

  shift_add_mult_4bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for out_valid after an accept edge; checks latency, busy length and product.
  task automatic wait_result(input logic [7:0] exp_p, input string tag);
    int lat = 0;
    int busy_n = 0;
    while (!out_valid && lat < 20) begin
      if (busy) busy_n++;
      tick();
      lat++;
    end
    check({tag, " latency"}, 16'(lat), 16'd4);
    check({tag, " busy"}, 16'(busy_n), 16'd4);
    check({tag, " p"}, {8'h00, p}, {8'h00, exp_p});
  endtask

  task automatic do_op(input logic [3:0] ta, input logic [3:0] tb_v, input string tag);
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    out_ready = 1'b0;
    #1;
    check({tag, " in_ready"}, {15'd0, in_ready}, 16'd1);
    tick();
    in_valid = 1'b0;
    wait_result(8'(int'(ta) * int'(tb_v)), tag);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, {15'd0, out_valid}, 16'd0);
  endtask

  initial begin
    logic [7:0] held_p;
    logic [7:0] expq[$];
    logic [7:0] exp_v;
    logic [7:0] pv;
    logic       fire_in, fire_out, hold;
    int idx, got, cyc;

    // Reset state
    #1;
    check("rst out_valid", {15'd0, out_valid}, 16'd0);
    check("rst busy", {15'd0, busy}, 16'd0);
    check("rst in_ready", {15'd0, in_ready}, 16'd1);
    check("rst p", {8'h00, p}, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();

    // 15x15
    do_op(4'hF, 4'hF, "15x15");
    check("15x15 const", {8'h00, p}, 16'h00E1);
    release_out("15x15");

    // Zero operands, no early exit
    do_op(4'h0, 4'hB, "0xB");
    release_out("0xB");
    do_op(4'h9, 4'h0, "9x0");
    release_out("9x0");

    // Backpressure
    do_op(4'h6, 4'h7, "6x7");
    held_p = p;
    check("6x7 const", {8'h00, p}, 16'h002A);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp out_valid", {15'd0, out_valid}, 16'd1);
      check("bp p stable", {8'h00, p}, {8'h00, held_p});
      check("bp in_ready", {15'd0, in_ready}, 16'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp in_ready follows", {15'd0, in_ready}, 16'd1);
    tick();
    out_ready = 1'b0;
    check("bp done", {15'd0, out_valid}, 16'd0);
    check("bp p retained", {8'h00, p}, 16'h002A);

    // Back-to-back: new operands accepted in DONE
    do_op(4'h3, 4'h5, "3x5");
    a = 4'h7;
    b = 4'h9;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    check("b2b in_ready", {15'd0, in_ready}, 16'd1);
    check("b2b p", {8'h00, p}, 16'h000F);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b out_valid drop", {15'd0, out_valid}, 16'd0);
    check("b2b no idle", {15'd0, busy}, 16'd1);
    wait_result(8'h3F, "7x9");
    release_out("7x9");

    // Reset during the 2nd CALC cycle
    a = 4'hC;
    b = 4'hD;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("mid busy", {15'd0, busy}, 16'd1);
    rst_n = 1'b0;
    #1;
    check("mid rst out_valid", {15'd0, out_valid}, 16'd0);
    check("mid rst busy", {15'd0, busy}, 16'd0);
    check("mid rst in_ready", {15'd0, in_ready}, 16'd1);
    check("mid rst p", {8'h00, p}, 16'h0000);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post rst no out", {15'd0, out_valid}, 16'd0);
    end
    out_ready = 1'b0;

    // Exhaustive sweep with random gaps; model is a FIFO of a*b
    idx = 0;
    got = 0;
    cyc = 0;
    while ((idx < 256 || got < 256) && cyc < 20000) begin
      a = 4'(idx >> 4);
      b = 4'(idx);
      in_valid = (idx < 256) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      fire_in = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      hold = out_valid && !out_ready;
      pv = p;
      tick();
      cyc++;
      if (fire_in) begin
        expq.push_back(8'((idx >> 4) * (idx & 15)));
        idx++;
      end
      if (fire_out) begin
        check("sweep pending", 16'(expq.size() > 0), 16'd1);
        exp_v = (expq.size() > 0) ? expq.pop_front() : 8'h00;
        check("sweep p", {8'h00, pv}, {8'h00, exp_v});
        got++;
      end
      if (hold) begin
        check("sweep hold valid", {15'd0, out_valid}, 16'd1);
        check("sweep hold p", {8'h00, p}, {8'h00, pv});
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("sweep accepted", 16'(idx), 16'd256);
    check("sweep delivered", 16'(got), 16'd256);
    check("sweep leftover", 16'(expq.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
